// File: rtl/hld_multi.sv
// hld_multi: harmonic-lock detector for a delay-line phase detector.
// Counts 0->1 edges in each tap snapshot and classifies the snapshot. Good
// snapshots build up lock; bad (harmonic or stuck) snapshots pulse a
// phase-detector reset and then wait out a settle window.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   en          detector enable; low forces IDLE
//   stuck_en    classify zero-edge snapshots as bad
//   sample_vld  strobe: tap_q holds a valid snapshot
//   tap_q       tap snapshot, bit 0 = first tap
//   reset_pd    registered phase-detector reset pulse
//   locked      registered lock indication
//   edge_cnt    edge count of the last accepted snapshot
//   retry_cnt   saturating count of reset pulses issued
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | detector disabled, counters cleared
// S_CHECK   | accepting snapshots, hunting for lock
// S_RST_PD  | reset_pd asserted, PULSE_LEN cycles
// S_HOLDOFF | settle window, snapshots ignored
// S_LOCKED  | locked; bad snapshots can still trigger reset
module hld_multi #(
  parameter int NTAPS       = 8,
  parameter int CONFIRM     = 2,
  parameter int LOCK_CNT    = 4,
  parameter int PULSE_LEN   = 4,
  parameter int HOLDOFF_LEN = 16,
  parameter int RETRY_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     stuck_en,
  input  logic                     sample_vld,
  input  logic [NTAPS-1:0]         tap_q,
  output logic                     reset_pd,
  output logic                     locked,
  output logic [$clog2(NTAPS)-1:0] edge_cnt,
  output logic [RETRY_W-1:0]       retry_cnt
);

  localparam int EW   = $clog2(NTAPS);
  localparam int TMAX = (PULSE_LEN > HOLDOFF_LEN) ? PULSE_LEN : HOLDOFF_LEN;
  // timer only ever holds TMAX-1
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_RST_PD  = 3'd2,
    S_HOLDOFF = 3'd3,
    S_LOCKED  = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      good_cnt, good_nxt, good_inc;
  logic [3:0]      bad_cnt, bad_nxt, bad_inc;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic [EW-1:0]   edge_nxt;
  logic [EW-1:0]   edges;
  logic            is_good, is_bad;

  // At most NTAPS/2 edges are possible, which always fits in EW bits.
  always_comb begin
    edges = '0;
    for (int i = 0; i < NTAPS - 1; i++) begin
      edges = edges + EW'(~tap_q[i] & tap_q[i+1]);
    end
  end

  assign is_good  = (edges == EW'(1));
  assign is_bad   = (edges > EW'(1)) | (stuck_en & (edges == '0));
  assign good_inc = (good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1;
  assign bad_inc  = (bad_cnt == 4'hF) ? bad_cnt : bad_cnt + 4'd1;

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    tmr_nxt   = tmr;
    retry_nxt = retry_cnt;
    edge_nxt  = edge_cnt;
    if (!en) begin
      // disable wins over any lock/confirm event in the same cycle
      state_nxt = S_IDLE;
      good_nxt  = '0;
      bad_nxt   = '0;
      tmr_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_CHECK;
          good_nxt  = '0;
          bad_nxt   = '0;
        end
        S_CHECK, S_LOCKED: begin
          if (sample_vld) begin
            edge_nxt = edges;
            if (is_good) begin
              good_nxt = good_inc;
              bad_nxt  = '0;
              if (state == S_CHECK && good_inc == 4'(LOCK_CNT))
                state_nxt = S_LOCKED;
            end else if (is_bad) begin
              bad_nxt  = bad_inc;
              good_nxt = '0;
              if (bad_inc == 4'(CONFIRM)) begin
                state_nxt = S_RST_PD;
                tmr_nxt   = TW'(PULSE_LEN - 1);
                if (~&retry_cnt)
                  retry_nxt = retry_cnt + RETRY_W'(1);
              end
            end
          end
        end
        S_RST_PD: begin
          if (tmr == '0) begin
            state_nxt = S_HOLDOFF;
            tmr_nxt   = TW'(HOLDOFF_LEN - 1);
          end else begin
            tmr_nxt = tmr - TW'(1);
          end
        end
        S_HOLDOFF: begin
          if (tmr == '0) begin
            state_nxt = S_CHECK;
            good_nxt  = '0;
            bad_nxt   = '0;
          end else begin
            tmr_nxt = tmr - TW'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they track the FSM
  // without any input-to-output combinational path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      tmr       <= '0;
      retry_cnt <= '0;
      edge_cnt  <= '0;
      reset_pd  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
      tmr       <= tmr_nxt;
      retry_cnt <= retry_nxt;
      edge_cnt  <= edge_nxt;
      reset_pd  <= (state_nxt == S_RST_PD);
      locked    <= (state_nxt == S_LOCKED);
    end
  end

endmodule

// File: doc/hld_multi.md
HLD_MULTI -- requirements
Module: hld_multi

Interface
REQ-001 Parameter NTAPS, default 8: number of delay-line tap samples per snapshot; legal range 3..32.
REQ-002 Parameter CONFIRM, default 2: consecutive bad snapshots needed to trigger a phase-detector reset; legal range 1..15.
REQ-003 Parameter LOCK_CNT, default 4: consecutive good snapshots needed to declare lock; legal range 1..15.
REQ-004 Parameter PULSE_LEN, default 4: reset_pd pulse width in clk cycles; legal range >=1.
REQ-005 Parameter HOLDOFF_LEN, default 16: settle cycles after a reset pulse; legal range >=1.
REQ-006 Parameter RETRY_W, default 4: width of retry_cnt.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 en  in  1  detector enable.
REQ-010 stuck_en  in  1  1 = a snapshot with zero edges is also classified bad.
REQ-011 sample_vld  in  1  one-cycle strobe: tap_q holds a valid snapshot.
REQ-012 tap_q  in  NTAPS  tap snapshot, already synchronous to clk; bit 0 = first tap.
REQ-013 reset_pd  out  1  registered phase-detector reset pulse.
REQ-014 locked  out  1  registered lock indication.
REQ-015 edge_cnt  out  clog2(NTAPS)  edge count of the last accepted snapshot.
REQ-016 retry_cnt  out  RETRY_W  number of reset pulses issued, saturating.

Function
REQ-017 Edge = index i in 0..NTAPS-2 with tap_q[i]=0 and tap_q[i+1]=1; edge count is computed combinationally from tap_q.
REQ-018 Classification: exactly 1 edge = good; >=2 edges = bad (harmonic); 0 edges = bad if stuck_en=1, otherwise neutral (no counter changes).
REQ-019 Snapshot acceptance: a snapshot is accepted only in CHECK or LOCKED with sample_vld=1; edge_cnt updates on accepted snapshots only.
REQ-020 Counters: a good snapshot increments good_cnt (saturating) and clears bad_cnt; a bad snapshot increments bad_cnt and clears good_cnt.
REQ-021 FSM states: IDLE, CHECK, RST_PD, HOLDOFF, LOCKED.
REQ-022 IDLE -> CHECK when en=1; counters are cleared on entry to CHECK.
REQ-023 CHECK -> LOCKED on the accepted snapshot that makes good_cnt equal LOCK_CNT; locked=1 from the next cycle.
REQ-024 CHECK or LOCKED -> RST_PD on the accepted snapshot that makes bad_cnt equal CONFIRM; reset_pd=1 and locked=0 from the next cycle.
REQ-025 RST_PD: reset_pd is held high exactly PULSE_LEN cycles, then the FSM goes to HOLDOFF; retry_cnt increments once per pulse and saturates at all-ones.
REQ-026 HOLDOFF: reset_pd=0, sample_vld is ignored for exactly HOLDOFF_LEN cycles, then the FSM goes to CHECK.
REQ-027 LOCKED: good snapshots clear bad_cnt; neutral snapshots change nothing; locked stays 1 until the transition in REQ-024 or REQ-028.
REQ-028 en=0 in any state -> IDLE on the next cycle: reset_pd=0, locked=0, counters cleared; en=0 takes priority over a simultaneous confirm or lock event.
REQ-029 retry_cnt and edge_cnt are preserved across en toggles and cleared only by rst.
REQ-030 All outputs are driven directly from flops; there is no combinational path from input to output.

Reset
REQ-031 With rst=1 at a clk edge: state=IDLE, reset_pd=0, locked=0, edge_cnt=0, retry_cnt=0, all internal counters 0.
REQ-032 rst has priority over every other input, including mid-pulse in RST_PD and during HOLDOFF.

Verification
REQ-033 Defaults, en=1, 4 snapshots of tap_q=8'b1111_0000 (1 edge) -> locked=1 the cycle after the 4th snapshot, reset_pd stays 0, edge_cnt=1.
REQ-034 Defaults, 2 snapshots of tap_q=8'b1100_1100 (2 edges) -> reset_pd high for exactly 4 cycles starting the cycle after the 2nd snapshot, retry_cnt=1, snapshots ignored for the next 16 cycles.
REQ-035 From locked, 1 bad snapshot, then 1 good, then 1 bad -> no reset pulse and locked remains 1; two consecutive bad snapshots -> locked=0 and reset_pd pulses.
REQ-036 tap_q=8'h00 x3: stuck_en=0 -> no state change; stuck_en=1 -> reset pulse after the 2nd snapshot.
REQ-037 en dropped on the same cycle as the confirming bad snapshot -> IDLE, no pulse, retry_cnt unchanged; rst asserted during pulse cycle 2 -> reset_pd=0 next cycle, retry_cnt=0.
REQ-038 RETRY_W=2, 5 forced harmonic cycles -> retry_cnt saturates at 3.
